// File: rtl/dcd_inst_buf.sv
// dcd_inst_buf
// ------------
// Decoded-instruction buffer on the consumer side of the 66-bit decoded
// instruction bus. Valid packets (bit 65 set) are queued in a DEPTH-entry
// FIFO. The head entry is presented raw on inst_out and unpacked into its
// register, immediate, PC and class fields. flush_in empties the buffer on a
// misprediction.
//
// Optional feature (macro DCD_BUF_BYPASS_EN):
//   When the buffer is empty and issue is ready, a valid input passes
//   straight to the head outputs in the same cycle and is not stored.
//   Without the macro, every head output comes from stored state.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   dcd_inst_in   packed decoded instruction, [65] = valid
//   flush_in      discard all entries and the current input
//   issue_rdy_in  downstream takes the head entry this cycle
//   full_out      occupancy == DEPTH, decode must hold its packet
//   cnt_out       current occupancy
//   vld_out       head entry valid
//   inst_out      raw head entry (zero when vld_out is low)
//   rs/rd/rt_out, rs_v/rd_v/rt_v_out, imm_out, pc_out   head fields
//   is_brn_out    head brn field non-zero
//   is_mem_out    head MemRd or MemWr set

module dcd_inst_buf #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [65:0]       dcd_inst_in,
  input  logic              flush_in,
  input  logic              issue_rdy_in,
  output logic              full_out,
  output logic [ADDR_W:0]   cnt_out,
  output logic              vld_out,
  output logic [65:0]       inst_out,
  output logic [3:0]        rs_out,
  output logic [3:0]        rd_out,
  output logic [3:0]        rt_out,
  output logic              rs_v_out,
  output logic              rd_v_out,
  output logic              rt_v_out,
  output logic [15:0]       imm_out,
  output logic [15:0]       pc_out,
  output logic              is_brn_out,
  output logic              is_mem_out
);

  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [65:0]       mem_r [DEPTH];
  logic [ADDR_W-1:0] head_r;
  logic [ADDR_W-1:0] tail_r;
  logic [ADDR_W:0]   cnt_r;

  logic              full_s;
  logic              empty_s;
  logic              byp_s;
  logic              push_s;
  logic              pop_s;
  logic              vld_s;
  logic [65:0]       inst_s;

  assign full_s  = (cnt_r == CNT_FULL);
  assign empty_s = (cnt_r == CNT_ZERO);

`ifdef DCD_BUF_BYPASS_EN
  // Empty buffer + ready issue: hand the input straight through.
  assign byp_s = empty_s & dcd_inst_in[65] & issue_rdy_in & ~flush_in;
`else
  assign byp_s = 1'b0;
`endif

  // Push/pop qualification; a full buffer never accepts, even while popping.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (flush_in) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = dcd_inst_in[65] & ~full_s & ~byp_s;
      pop_s  = ~empty_s & issue_rdy_in;
    end
  end

  // Pointer and occupancy state; flush outranks push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_r <= PTR_ZERO;
      tail_r <= PTR_ZERO;
      cnt_r  <= CNT_ZERO;
    end else if (flush_in) begin
      head_r <= PTR_ZERO;
      tail_r <= PTR_ZERO;
      cnt_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s) begin
        head_r <= head_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[tail_r] <= dcd_inst_in;
    end
  end

  // Head view: bypassed input, stored head, or all zeros when nothing valid.
  always_comb begin
    inst_s = {66{1'b0}};
    vld_s  = 1'b0;
    if (byp_s) begin
      inst_s = dcd_inst_in;
      vld_s  = 1'b1;
    end else if (!empty_s) begin
      inst_s = mem_r[head_r];
      vld_s  = 1'b1;
    end else begin
      inst_s = {66{1'b0}};
      vld_s  = 1'b0;
    end
  end

  assign full_out   = full_s;
  assign cnt_out    = cnt_r;
  assign vld_out    = vld_s;
  assign inst_out   = inst_s;

  assign rs_v_out   = inst_s[64];
  assign rs_out     = inst_s[63:60];
  assign rd_v_out   = inst_s[59];
  assign rd_out     = inst_s[58:55];
  assign rt_v_out   = inst_s[54];
  assign rt_out     = inst_s[53:50];
  assign imm_out    = inst_s[48:33];
  assign is_brn_out = |inst_s[31:30];
  assign is_mem_out = inst_s[26] | inst_s[25];
  assign pc_out     = inst_s[15:0];

endmodule

// File: tb/tb_dcd_inst_buf.sv
// Self-checking bench for dcd_inst_buf: a table of cycle vectors with
// expected post-edge outputs, a queue scoreboard checked every cycle, and
// hand-written sequences for reset, wrap, flush, fields and bypass.
module tb_dcd_inst_buf;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [65:0]       dcd_inst_in;
  logic              flush_in;
  logic              issue_rdy_in;
  logic              full_out;
  logic [ADDR_W:0]   cnt_out;
  logic              vld_out;
  logic [65:0]       inst_out;
  logic [3:0]        rs_out, rd_out, rt_out;
  logic              rs_v_out, rd_v_out, rt_v_out;
  logic [15:0]       imm_out, pc_out;
  logic              is_brn_out, is_mem_out;

  dcd_inst_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .dcd_inst_in(dcd_inst_in), .flush_in(flush_in),
    .issue_rdy_in(issue_rdy_in), .full_out(full_out), .cnt_out(cnt_out),
    .vld_out(vld_out), .inst_out(inst_out), .rs_out(rs_out), .rd_out(rd_out),
    .rt_out(rt_out), .rs_v_out(rs_v_out), .rd_v_out(rd_v_out),
    .rt_v_out(rt_v_out), .imm_out(imm_out), .pc_out(pc_out),
    .is_brn_out(is_brn_out), .is_mem_out(is_mem_out)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [65:0] sb_q [$];
  logic [65:0] bubble = 66'h0;
  logic [65:0] fpkt;

  typedef struct {
    logic [65:0] pkt;
    logic        rdy;
    logic        fl;
    logic [3:0]  e_cnt;
    logic        e_full;
    logic        e_vld;
    logic [15:0] e_pc;
  } vec_t;
  vec_t vecs [17];

  function automatic logic [65:0] mk(input logic [15:0] pc);
    logic [65:0] p;
    p = 66'h0;
    p[65] = 1'b1;
    p[15:0] = pc;
    return p;
  endfunction

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive, check head/occupancy mid-cycle against the
  // scoreboard, update the scoreboard, then step past the rising edge.
  task automatic cyc(input logic [65:0] pkt, input logic rdy, input logic fl);
    logic byp, do_pop, do_push;
    logic [65:0] e_inst;
    int sz;
    dcd_inst_in  = pkt;
    issue_rdy_in = rdy;
    flush_in     = fl;
    @(negedge clk);
    sz = sb_q.size();
`ifdef DCD_BUF_BYPASS_EN
    byp = (sz == 0) && pkt[65] && rdy && !fl;
`else
    byp = 1'b0;
`endif
    e_inst = byp ? pkt : ((sz > 0) ? sb_q[0] : 66'h0);
    chk("sb_vld",  vld_out,  66'((sz > 0) || byp));
    chk("sb_inst", inst_out, e_inst);
    chk("sb_pc",   pc_out,   66'(e_inst[15:0]));
    chk("sb_cnt",  cnt_out,  66'(sz));
    chk("sb_full", full_out, 66'(sz == DEPTH));
    do_pop  = (sz > 0) && rdy && !fl;
    do_push = pkt[65] && (sz < DEPTH) && !fl && !byp;
    if (fl) begin
      sb_q.delete();
    end else begin
      if (do_pop)  void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(pkt);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: fill 8, 9th ignored while full, drain 8 in order.
    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{pkt: mk(16'(i)), rdy: 1'b0, fl: 1'b0, e_cnt: 4'(i + 1),
                  e_full: (i == 7), e_vld: 1'b1, e_pc: 16'h0000};
    end
    vecs[8] = '{pkt: mk(16'h0100), rdy: 1'b0, fl: 1'b0, e_cnt: 4'd8,
                e_full: 1'b1, e_vld: 1'b1, e_pc: 16'h0000};
    for (int k = 0; k < 8; k++) begin
      vecs[9 + k] = '{pkt: 66'h0, rdy: 1'b1, fl: 1'b0, e_cnt: 4'(7 - k),
                      e_full: 1'b0, e_vld: (k < 7),
                      e_pc: (k < 7) ? 16'(k + 1) : 16'h0000};
    end

    // Reset held with a valid packet waiting at the input.
    rst = 1'b1;
    dcd_inst_in = mk(16'h0040);
    issue_rdy_in = 1'b0;
    flush_in = 1'b0;
    @(negedge clk);
    chk("rst_vld",  vld_out,  66'h0);
    chk("rst_cnt",  cnt_out,  66'h0);
    chk("rst_full", full_out, 66'h0);
    chk("rst_inst", inst_out, 66'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(mk(16'h0040), 1'b0, 1'b0);
    chk("rst_rel_pc",  pc_out,  66'h0040);
    chk("rst_rel_cnt", cnt_out, 66'h1);
    cyc(bubble, 1'b1, 1'b0);

    // Table-driven fill/overflow/drain.
    for (int i = 0; i < 17; i++) begin
      cyc(vecs[i].pkt, vecs[i].rdy, vecs[i].fl);
      chk("tbl_cnt",  cnt_out,  66'(vecs[i].e_cnt));
      chk("tbl_full", full_out, 66'(vecs[i].e_full));
      chk("tbl_vld",  vld_out,  66'(vecs[i].e_vld));
      chk("tbl_pc",   pc_out,   66'(vecs[i].e_pc));
    end

    // Full with simultaneous pop: pop happens, push refused.
    for (int i = 0; i < 8; i++) cyc(mk(16'h0500 + 16'(i)), 1'b0, 1'b0);
    cyc(mk(16'h05FF), 1'b1, 1'b0);
    chk("full_pop_cnt", cnt_out, 66'd7);
    for (int i = 0; i < 7; i++) cyc(bubble, 1'b1, 1'b0);
    chk("full_pop_empty", vld_out, 66'h0);

    // Steady push+pop at count 3 across pointer wrap.
    for (int i = 0; i < 3; i++) cyc(mk(16'h0200 + 16'(i)), 1'b0, 1'b0);
    for (int k = 3; k < 23; k++) begin
      cyc(mk(16'h0200 + 16'(k)), 1'b1, 1'b0);
      chk("wrap_cnt", cnt_out, 66'd3);
    end
    chk("wrap_pc", pc_out, 66'h0214);
    for (int i = 0; i < 3; i++) cyc(bubble, 1'b1, 1'b0);

    // All-zero bus: no pushes.
    cyc(mk(16'h0300), 1'b0, 1'b0);
    cyc(mk(16'h0301), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(bubble, 1'b0, 1'b0);
      chk("bubble_cnt", cnt_out, 66'd2);
    end

    // Flush at count 5 together with a valid push.
    for (int i = 2; i < 5; i++) cyc(mk(16'h0300 + 16'(i)), 1'b0, 1'b0);
    chk("pre_flush_cnt", cnt_out, 66'd5);
    cyc(mk(16'h03FF), 1'b1, 1'b1);
    chk("flush_cnt",  cnt_out,  66'h0);
    chk("flush_vld",  vld_out,  66'h0);
    chk("flush_inst", inst_out, 66'h0);
    cyc(bubble, 1'b0, 1'b0);

    // Field unpacking of a stored head.
    fpkt = 66'h0;
    fpkt[65] = 1'b1;
    fpkt[64] = 1'b1;
    fpkt[63:60] = 4'h3;
    fpkt[54] = 1'b1;
    fpkt[53:50] = 4'hA;
    fpkt[49] = 1'b1;
    fpkt[48:33] = 16'hFFF8;
    fpkt[31:30] = 2'b01;
    fpkt[26] = 1'b1;
    fpkt[15:0] = 16'h0123;
    cyc(fpkt, 1'b0, 1'b0);
    chk("f_rs",   rs_out,     66'h3);
    chk("f_rs_v", rs_v_out,   66'h1);
    chk("f_rt",   rt_out,     66'hA);
    chk("f_rt_v", rt_v_out,   66'h1);
    chk("f_rd",   rd_out,     66'h0);
    chk("f_rd_v", rd_v_out,   66'h0);
    chk("f_imm",  imm_out,    66'hFFF8);
    chk("f_brn",  is_brn_out, 66'h1);
    chk("f_mem",  is_mem_out, 66'h1);
    chk("f_pc",   pc_out,     66'h0123);
    cyc(bubble, 1'b1, 1'b0);
    chk("f_empty_brn", is_brn_out, 66'h0);

    // Empty buffer, ready issue: bypass passes through, otherwise stored.
    cyc(fpkt, 1'b1, 1'b0);
`ifdef DCD_BUF_BYPASS_EN
    chk("byp_cnt", cnt_out, 66'h0);
`else
    chk("nobyp_cnt", cnt_out, 66'h1);
`endif
    cyc(bubble, 1'b1, 1'b0);

    // Reset asserted mid-stream.
    for (int i = 0; i < 3; i++) cyc(mk(16'h0400 + 16'(i)), 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("mid_rst_cnt", cnt_out, 66'h0);
    chk("mid_rst_vld", vld_out, 66'h0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(bubble, 1'b0, 1'b0);
    cyc(mk(16'h0440), 1'b0, 1'b0);
    chk("post_rst_pc", pc_out, 66'h0440);
    cyc(bubble, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcd_inst_buf.md
# dcd_inst_buf

Decoded-instruction buffer on the consumer side of the 66-bit decoded-instruction bus produced by the decode interpreter. Accepts one packed decoded instruction per cycle, stores it in a DEPTH-entry FIFO, back-pressures decode when full, and presents the head entry to the allocation/issue stage both raw and unpacked into fields. A flush input discards all buffered instructions on misprediction.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2
- ADDR_W, 3, log2(DEPTH)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- dcd_inst_in  input  66  packed decoded instruction; bit 65 is the instruction-valid bit
- flush_in  input  1  discard all entries and the current input
- issue_rdy_in  input  1  downstream accepts head entry this cycle
- full_out  output  1  count == DEPTH; decode must hold its packet
- cnt_out  output  ADDR_W+1  current occupancy
- vld_out  output  1  head entry valid
- inst_out  output  66  raw head entry
- rs_out, rd_out, rt_out  output  4 each  register fields of head
- rs_v_out, rd_v_out, rt_v_out  output  1 each  register-valid flags of head
- imm_out  output  16  immediate of head
- pc_out  output  16  recovery PC of head
- is_brn_out  output  1  head brn field != 0
- is_mem_out  output  1  head MemRd or MemWr set

## Operation
- Packet layout (bit positions fixed): [65] valid, [64] Rs_v, [63:60] Rs, [59] Rd_v, [58:55] Rd, [54] Rt_v, [53:50] Rt, [49] im_v, [48:33] imm, [32] LDI, [31:30] brn, [29] jmp_v, [28:27] jmp, [26] MemRd, [25] MemWr, [24:22] ALU_ctrl, [21] to_add, [20] to_mult, [19] to_addr, [18] invRt, [17] RegWr, [16] pred_result, [15:0] PC.
- Push: dcd_inst_in[65] == 1 and count < DEPTH and flush_in == 0. A packet with bit 65 == 0 is never stored (all-zero bus = bubble).
- Push while full: packet ignored, no state change; decode holds it because full_out is high.
- Pop: vld_out && issue_rdy_in && !flush_in; head pointer advances.
- Simultaneous push and pop: both happen, count unchanged. When full, no push is accepted even if a pop occurs in the same cycle.
- Flush: highest priority; at the next edge head = tail = 0, count = 0; the input packet and any pop in that cycle are discarded.
- Pointers ADDR_W bits, wrap modulo DEPTH; count is a separate ADDR_W+1 counter.
- Unpacked outputs are pure slices/reductions of inst_out; when vld_out == 0, inst_out and all unpacked outputs are driven to 0.

## Timing
- Reset (async): count 0, pointers 0, full_out 0, vld_out 0, cnt_out 0, inst_out and all field outputs 0. Storage array need not be reset.
- full_out, vld_out, cnt_out are registered-state decodes (no combinational path from any input).
- Push-to-visible latency: 1 cycle (entry pushed at edge N is on inst_out after edge N when it is the head).
- Reset deasserted mid-stream: buffer restarts empty; no entry survives.

## Configuration
- DCD_BUF_BYPASS_EN defined: when count == 0, a valid input with issue_rdy_in == 1 and flush_in == 0 passes combinationally to inst_out/vld_out in the same cycle and is not stored; if issue_rdy_in == 0 it is stored normally. vld_out then depends combinationally on dcd_inst_in[65] and flush_in.
- Not defined: no bypass; minimum latency 1 cycle, all outputs from registers.

## Test plan
- Reset with packet PC=0x0040 at the input and rst high -> vld_out 0, cnt_out 0, full_out 0; after release the packet is pushed and the next cycle shows pc_out 0x0040.
- Push 8 packets (PC 0x0000..0x0007), issue_rdy_in 0 -> full_out 1, cnt_out 8; a 9th packet is ignored; popping 8 yields PCs 0x0000..0x0007 in order, then vld_out 0.
- Count 3 with push and pop in one cycle -> cnt_out stays 3, order preserved across pointer wrap (run 20 packets).
- Input bus all zeros for 5 cycles -> cnt_out unchanged.
- Count 5, flush_in together with a valid push -> next cycle cnt_out 0, vld_out 0, pushed packet lost.
- Head packet with Rs=0x3, Rt=0xA, imm=0xFFF8, brn=01, MemRd=1 -> rs_out 0x3, rt_out 0xA, imm_out 0xFFF8, is_brn_out 1, is_mem_out 1; with DCD_BUF_BYPASS_EN, empty buffer and issue_rdy_in 1, the same packet appears on inst_out in the same cycle and cnt_out stays 0.
